dct_block_sequencer: RTL and testbench
======================================

Name: dct_block_sequencer

Overview:
Sequences 8x8 pixel blocks into the dct_idct core. The core takes one xin sample per clock with no stall and has no valid signalling of its own. Upstream pixels arrive on a valid/ready handshake and are captured into a two-bank (ping-pong) 64x8 buffer. Each complete block is then streamed gap-free into the core, and a latency-matched marker pipe tags the core's dct_2d output with valid, first/last and row/column index.

Parameters:
CORE_LATENCY, 96, clock cycles from a sample on core_xin to its result on core_dct (must be >= 1)
DATA_W, 8, pixel width (core xin width)
COEF_W, 12, coefficient width (core dct_2d width)

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous, active-low reset
in_valid  in  1  upstream pixel valid
in_ready  out  1  sequencer can accept a pixel
in_data  in  DATA_W  pixel, raster order within the 8x8 block (row-major)
core_xin  out  DATA_W  registered drive to core xin
core_dct  in  COEF_W  core dct_2d output
out_valid  out  1  out_data holds a block coefficient
out_data  out  COEF_W  registered copy of core_dct
out_first  out  1  coefficient index 0 of a block
out_last  out  1  coefficient index 63 of a block
out_row  out  3  coefficient row (index[5:3])
out_col  out  3  coefficient column (index[2:0])
busy  out  1  any bank non-empty or any marker in flight
blk_count  out  16  blocks completed on output, wraps at 65535 -> 0

Behaviour:
- Reset, with RST low asynchronous:
  - All outputs 0 (core_xin=0, in_ready=0, out_valid=0, blk_count=0).
  - Both banks EMPTY, write/read pointers 0, marker pipe cleared.
  - in_ready rises the first cycle after RST deasserts.
- Reset mid-block: the partial fill is discarded, and in-flight core results are never flagged valid.
- Per-bank states: EMPTY -> FILLING (first handshake) -> FULL (64th handshake) -> STREAMING (launch) -> EMPTY (after sample 63 is driven).
- Write side:
  - A handshake occurs when in_valid & in_ready at a rising edge.
  - The write pointer (6 bits) addresses the fill bank. At pointer 63 it wraps to 0 and the fill bank toggles.
  - in_ready = 1 unless both banks are FULL/STREAMING with neither EMPTY. It is computed from registered state only, with no combinational in_valid -> in_ready path.
- Stream FSM states are IDLE and STREAM:
  - IDLE -> STREAM on the cycle a bank is FULL.
  - In STREAM, the read pointer advances every clock and core_xin = bank[rd_ptr] (registered).
  - At rd_ptr 63: if the other bank is FULL, continue directly into it with no gap cycle; otherwise go to IDLE.
  - In IDLE, core_xin = 0.
- Launch timing: sample 0 of a block appears on core_xin at edge E+2, where E is the edge of the 64th input handshake and the streamer was IDLE.
- Simultaneous events:
  - A bank finishing streaming at the same edge the other bank completes fill: streaming continues seamlessly.
  - A bank freed at the same edge in_valid is presented: in_ready may already be 1 that cycle, since the freeing is registered.
- Marker pipe:
  - CORE_LATENCY-deep shift register of {valid, idx[5:0]}, loaded in step with core_xin.
  - At the tail, out_data <= core_dct and out_valid <= tail.valid.
  - Result: the coefficient for core_xin sample k appears at E+2+k+CORE_LATENCY+1.
- Output flags:
  - out_first when idx==0; out_last when idx==63; out_row/out_col from idx.
  - All are 0 when out_valid is 0.
- blk_count increments on the edge that presents out_last.
- busy = |bank_state | |marker_valid_bits.
- No backpressure on the output side. The downstream consumer must accept every out_valid cycle.

Test Plan:
- Reset/idle: hold RST low for 2 cycles, release with in_valid=0 -> in_ready=1 next cycle; core_xin=0, out_valid=0, busy=0, blk_count=0.
- Single block, continuous: send the 64-pixel block 0x28,0x21,0x21,0x16,0x1A,0x28,0x24,0x1A,... ending 0x0C,0x04,0x08,0x00 with in_valid held 1.
  - core_xin shows the same 64 values from E+2 onward, then 0.
  - out_valid spans 64 cycles starting E+3+CORE_LATENCY: out_first on the first cycle, out_last with row=7,col=7 on the last; blk_count=1.
- Four blocks back-to-back with in_valid constant:
  - core_xin is gap-free across all 256 samples.
  - in_ready never drops, or drops only when both banks are occupied.
  - out_valid is contiguous for 256 cycles; blk_count=4.
- Throttled input: in_valid toggles 1,0,1,0 -> core_xin still streams each block as 64 consecutive cycles, with zeros between blocks; the out_row/out_col sequence runs 0,0 .. 7,7 per block.
- Backpressure: hold the core stream busy with a full second bank, then offer a third block -> in_ready=0 until the first bank finishes streaming; no pixel is lost or duplicated when checked against the expected core_xin sequence.
- Reset mid-operation: assert RST after 40 pixels of block 2 with block 1 in the core.
  - Outputs clear immediately and no out_valid occurs for the old blocks.
  - A fresh block after release is processed normally; blk_count restarts at 0 and counts to 1.

Source files
------------

// File: rtl/dct_block_sequencer.sv
// Purpose: captures 8x8 pixel blocks into a ping-pong buffer, streams each block gap-free into the dct core, tags core results.
// Latency: sample k of a block reaches core_xin 2+k cycles after its 64th input handshake; its coefficient appears CORE_LATENCY+1 cycles later.
// Backpressure: in_ready drops only while both banks are full or streaming; the output side has no backpressure.
module dct_block_sequencer #(
  parameter int CORE_LATENCY = 96,
  parameter int DATA_W       = 8,
  parameter int COEF_W       = 12
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] core_xin,
  input  logic [COEF_W-1:0] core_dct,
  output logic              out_valid,
  output logic [COEF_W-1:0] out_data,
  output logic              out_first,
  output logic              out_last,
  output logic [2:0]        out_row,
  output logic [2:0]        out_col,
  output logic              busy,
  output logic [15:0]       blk_count
);

  typedef enum logic [1:0] {
    B_EMPTY     = 2'd0,
    B_FILLING   = 2'd1,
    B_FULL      = 2'd2,
    B_STREAMING = 2'd3
  } bank_st_t;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } strm_st_t;

  // Two 64-entry banks, addressed as {bank, pointer}.
  logic [DATA_W-1:0] mem [0:127];

  bank_st_t bank_st  [0:1];
  bank_st_t bank_nxt [0:1];
  strm_st_t strm_st;
  strm_st_t strm_nxt;

  logic       run;
  logic       wr_bank;
  logic [5:0] wr_ptr;
  logic       rd_bank;
  logic [5:0] rd_ptr;

  logic       hs;
  logic       fill_done;
  logic       other;
  logic       last_rd;
  logic       chain;
  logic       launch;

  // Marker pipe: stage 0 is aligned with core_xin, stage CORE_LATENCY with core_dct.
  logic [CORE_LATENCY:0]      mk_vld;
  logic [CORE_LATENCY:0][5:0] mk_idx;
  logic                       tail_vld;
  logic [5:0]                 tail_idx;

  // run holds in_ready low until the first edge after reset release.
  assign in_ready  = run && ((bank_st[wr_bank] == B_EMPTY) || (bank_st[wr_bank] == B_FILLING));
  assign hs        = in_valid && in_ready;
  assign fill_done = hs && (wr_ptr == 6'd63);
  assign other     = ~rd_bank;
  assign last_rd   = (strm_st == S_STREAM) && (rd_ptr == 6'd63);
  // Continue straight into the other bank if it is full, or becomes full on this very edge.
  assign chain     = last_rd && ((bank_st[other] == B_FULL) || (fill_done && (wr_bank == other)));
  assign launch    = (strm_st == S_IDLE) && (bank_st[rd_bank] == B_FULL);
  assign tail_vld  = mk_vld[CORE_LATENCY];
  assign tail_idx  = mk_idx[CORE_LATENCY];
  assign busy      = (bank_st[0] != B_EMPTY) || (bank_st[1] != B_EMPTY) || (|mk_vld);

  // Pixel storage; no reset needed, bank state decides what is meaningful.
  always_ff @(posedge CLK) begin
    if (hs) begin
      mem[{wr_bank, wr_ptr}] <= in_data;
    end
  end

  // Write pointer and fill bank advance on every handshake.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      run     <= 1'b0;
      wr_bank <= 1'b0;
      wr_ptr  <= 6'd0;
    end else begin
      run <= 1'b1;
      if (hs) begin
        wr_ptr <= wr_ptr + 6'd1;
        if (wr_ptr == 6'd63) begin
          wr_bank <= ~wr_bank;
        end
      end
    end
  end

  // Per-bank next state: fill events first, stream events take priority on overlap.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_nxt[b] = bank_st[b];
      if (hs && (wr_bank == 1'(b))) begin
        bank_nxt[b] = (wr_ptr == 6'd63) ? B_FULL : B_FILLING;
      end
      if (launch && (rd_bank == 1'(b))) begin
        bank_nxt[b] = B_STREAMING;
      end
      if (last_rd) begin
        if (rd_bank == 1'(b)) begin
          bank_nxt[b] = B_EMPTY;
        end else if (chain) begin
          bank_nxt[b] = B_STREAMING;
        end
      end
    end
  end

  // Bank state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bank_st[0] <= B_EMPTY;
      bank_st[1] <= B_EMPTY;
    end else begin
      bank_st[0] <= bank_nxt[0];
      bank_st[1] <= bank_nxt[1];
    end
  end

  // Stream FSM next state.
  always_comb begin
    strm_nxt = strm_st;
    case (strm_st)
      S_IDLE:   if (launch) strm_nxt = S_STREAM;
      S_STREAM: if (last_rd && !chain) strm_nxt = S_IDLE;
      default:  strm_nxt = S_IDLE;
    endcase
  end

  // Stream FSM state, read pointer and the bank to stream next.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      strm_st <= S_IDLE;
      rd_bank <= 1'b0;
      rd_ptr  <= 6'd0;
    end else begin
      strm_st <= strm_nxt;
      if (strm_st == S_STREAM) begin
        rd_ptr <= rd_ptr + 6'd1;
        if (rd_ptr == 6'd63) begin
          rd_bank <= ~rd_bank;
        end
      end
    end
  end

  // Registered core drive; zero whenever nothing is streaming.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      core_xin <= '0;
    end else if (strm_st == S_STREAM) begin
      core_xin <= mem[{rd_bank, rd_ptr}];
    end else begin
      core_xin <= '0;
    end
  end

  // Marker pipe follows each sample through the core.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mk_vld <= '0;
      mk_idx <= '0;
    end else begin
      mk_vld <= {mk_vld[CORE_LATENCY-1:0], (strm_st == S_STREAM)};
      mk_idx <= {mk_idx[CORE_LATENCY-1:0], rd_ptr};
    end
  end

  // Output register and completed-block counter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_row   <= 3'd0;
      out_col   <= 3'd0;
      blk_count <= 16'd0;
    end else begin
      out_valid <= tail_vld;
      out_data  <= core_dct;
      out_first <= tail_vld && (tail_idx == 6'd0);
      out_last  <= tail_vld && (tail_idx == 6'd63);
      out_row   <= tail_vld ? tail_idx[5:3] : 3'd0;
      out_col   <= tail_vld ? tail_idx[2:0] : 3'd0;
      if (tail_vld && (tail_idx == 6'd63)) begin
        blk_count <= blk_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dct_block_sequencer.sv
// Bench for dct_block_sequencer: random pixel blocks, a delay-line core model and a scoreboard.
// Expected coefficients are queued when a block is issued; a negedge monitor pops them on out_valid.
// Directed checks cover reset state, launch timing, output run lengths, backpressure and mid-block reset.
module tb_dct_block_sequencer;

  localparam int LAT = 96;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'd0;
  logic [7:0]  core_xin;
  logic [11:0] core_dct = 12'd0;
  logic        out_valid;
  logic [11:0] out_data;
  logic        out_first;
  logic        out_last;
  logic [2:0]  out_row;
  logic [2:0]  out_col;
  logic        busy;
  logic [15:0] blk_count;

  dct_block_sequencer #(.CORE_LATENCY(LAT), .DATA_W(8), .COEF_W(12)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .core_xin(core_xin), .core_dct(core_dct),
    .out_valid(out_valid), .out_data(out_data), .out_first(out_first), .out_last(out_last),
    .out_row(out_row), .out_col(out_col), .busy(busy), .blk_count(blk_count)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [11:0] d;
    logic        f;
    logic        l;
    logic [2:0]  r;
    logic [2:0]  c;
  } exp_t;

  exp_t       exp_q [$];
  int         runs_q [$];
  int         run_start_q [$];
  int         n_cmp = 0;
  int         n_fail = 0;
  int         exp_blk = 0;
  int         run_len = 0;
  int         cyc = 0;
  logic [7:0] pix [64];
  logic [7:0] xin_pipe [0:LAT-2];

  // Injective stand-in for the transform so lost or duplicated samples are visible.
  function automatic logic [11:0] coef(input logic [7:0] x);
    return 12'(int'(x) * 13 + 5);
  endfunction

  // Core model: result for the sample driven at edge t is on core_dct from edge t+LAT.
  always @(posedge CLK) begin
    xin_pipe[0] <= core_xin;
    for (int i = 1; i < LAT - 1; i++) xin_pipe[i] <= xin_pipe[i-1];
    core_dct <= coef(xin_pipe[LAT-2]);
  end

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  task automatic chk(input string name, input longint got, input longint req);
    n_cmp++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  // Monitor: scoreboard pop on every output beat, flag check on idle beats.
  initial forever begin
    exp_t got;
    exp_t e;
    @(negedge CLK);
    if (!RST) begin
      exp_q.delete();
      exp_blk = 0;
      run_len = 0;
    end
    got = {out_data, out_first, out_last, out_row, out_col};
    if (out_valid) begin
      if (run_len == 0) run_start_q.push_back(cyc);
      run_len++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out: got %h, required no output", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL out_beat: got %h, required %h (data,first,last,row,col)", got, e);
        end
        if (e.l) exp_blk++;
      end
      chk("blk_count_live", blk_count, exp_blk);
    end else begin
      if (run_len > 0) begin
        runs_q.push_back(run_len);
        run_len = 0;
      end
      chk("idle_flags", {out_first, out_last, out_row, out_col}, 0);
    end
  end

  task automatic do_reset();
    @(posedge CLK);
    #2;
    in_valid = 1'b0;
    RST = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_core_xin", core_xin, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_blk_count", blk_count, 0);
    repeat (2) @(posedge CLK);
    #2;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_core_xin", core_xin, 0);
    chk("post_rst_blk_count", blk_count, 0);
    runs_q.delete();
    run_start_q.delete();
  endtask

  task automatic fill_random();
    for (int k = 0; k < 64; k++) pix[k] = 8'($urandom_range(0, 255));
  endtask

  // Called at #1 after an edge; returns at #1 after the handshake edge.
  task automatic send_pixel(input logic [7:0] px, output int hs_cyc);
    bit ok;
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_data = px;
    do begin
      ok = in_ready;
      @(posedge CLK);
      #1;
      guard++;
    end while (!ok && guard < 2000);
    if (!ok) chk("handshake_timeout", 0, 1);
    hs_cyc = cyc;
  endtask

  task automatic send_block(input int n, input bit expect_out, input bit throttle, output int last_hs);
    exp_t e;
    if (expect_out) begin
      for (int k = 0; k < 64; k++) begin
        e.d = coef(pix[k]);
        e.f = (k == 0);
        e.l = (k == 63);
        e.r = 3'(k >> 3);
        e.c = 3'(k & 7);
        exp_q.push_back(e);
      end
    end
    last_hs = 0;
    for (int k = 0; k < n; k++) begin
      send_pixel(pix[k], last_hs);
      if (throttle) begin
        in_valid = 1'b0;
        @(posedge CLK);
        #1;
      end
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    in_valid = 1'b0;
    while ((busy || out_valid) && g < 3000) begin
      @(posedge CLK);
      #1;
      g++;
    end
    repeat (3) @(posedge CLK);
    #1;
    chk("idle_reached", (g < 3000), 1);
    chk("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic chk_runs(input int n, input int len);
    chk("run_count", runs_q.size(), n);
    for (int i = 0; i < runs_q.size(); i++) chk("run_len", runs_q[i], len);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e_hs;
    int tmp;

    // Reset / idle.
    do_reset();
    chk("idle_out_valid", out_valid, 0);

    // Single block, continuous input, exact launch and output timing.
    do_reset();
    fill_random();
    pix[0] = 8'h28; pix[1] = 8'h21; pix[2] = 8'h21; pix[3] = 8'h16;
    pix[4] = 8'h1A; pix[5] = 8'h28; pix[6] = 8'h24; pix[7] = 8'h1A;
    pix[60] = 8'h0C; pix[61] = 8'h04; pix[62] = 8'h08; pix[63] = 8'h00;
    send_block(64, 1'b1, 1'b0, e_hs);
    in_valid = 1'b0;
    @(posedge CLK);
    #1;
    for (int k = 0; k < 64; k++) begin
      @(posedge CLK);
      #1;
      chk("core_xin_sample", core_xin, pix[k]);
    end
    @(posedge CLK);
    #1;
    chk("core_xin_idle", core_xin, 0);
    wait_idle();
    chk_runs(1, 64);
    chk("first_out_cycle", (run_start_q.size() > 0) ? run_start_q[0] : -1, e_hs + 3 + LAT);
    chk("blk_count_single", blk_count, 1);

    // Four blocks back-to-back: one contiguous 256-beat output run.
    do_reset();
    for (int b = 0; b < 4; b++) begin
      fill_random();
      send_block(64, 1'b1, 1'b0, tmp);
    end
    wait_idle();
    chk_runs(1, 256);
    chk("blk_count_four", blk_count, 4);

    // Throttled input: each block streams alone, separated by idle gaps.
    do_reset();
    for (int b = 0; b < 2; b++) begin
      fill_random();
      send_block(64, 1'b1, 1'b1, tmp);
    end
    wait_idle();
    chk_runs(2, 64);
    chk("blk_count_throttled", blk_count, 2);

    // Backpressure: third block held off until the first bank drains.
    do_reset();
    fill_random();
    send_block(64, 1'b1, 1'b0, tmp);
    fill_random();
    send_block(64, 1'b1, 1'b0, tmp);
    in_valid = 1'b0;
    chk("bp_in_ready_low", in_ready, 0);
    @(posedge CLK);
    #1;
    chk("bp_in_ready_back", in_ready, 1);
    fill_random();
    send_block(64, 1'b1, 1'b0, tmp);
    wait_idle();
    chk_runs(1, 192);
    chk("blk_count_bp", blk_count, 3);

    // Reset mid-operation: nothing from before the reset may be flagged.
    do_reset();
    fill_random();
    send_block(64, 1'b0, 1'b0, tmp);
    fill_random();
    send_block(40, 1'b0, 1'b0, tmp);
    do_reset();
    repeat (LAT + 100) @(posedge CLK);
    #1;
    chk("mid_rst_no_output", runs_q.size() + run_len, 0);
    chk("mid_rst_blk_count", blk_count, 0);
    fill_random();
    send_block(64, 1'b1, 1'b0, tmp);
    wait_idle();
    chk_runs(1, 64);
    chk("mid_rst_blk_count_after", blk_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
